seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, maximum pattern length in bits (2..16).
REQ-002 SHALL have parameter LEN_W, default 5, width of pat_len (must hold MAX_LEN).
REQ-003 SHALL have parameter CNT_W, default 8, width of hit counter.
REQ-004 SHALL have port clk  input  1  clock, rising edge active.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port data  input  1  serial data bit.
REQ-007 SHALL have port data_valid  input  1  data is sampled only when high.
REQ-008 SHALL have port cfg_load  input  1  latch pattern, pat_len and overlap into internal config registers.
REQ-009 SHALL have port pattern  input  MAX_LEN  target pattern; pattern[pat_len-1] is the first bit received, pattern[0] the last.
REQ-010 SHALL have port pat_len  input  LEN_W  pattern length in bits.
REQ-011 SHALL have port overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-012 SHALL have port cnt_clr  input  1  synchronous clear of hit_cnt.
REQ-013 SHALL have port hit  output  1  Mealy pulse, combinational, high in the cycle the completing bit is valid.
REQ-014 SHALL have port hit_q  output  1  Moore-style pulse, hit registered one cycle.
REQ-015 SHALL have port hit_cnt  output  CNT_W  saturating count of hits.

Function
REQ-016 SHALL keep a history shift register (MAX_LEN-1 bits) and a fill counter of valid bits received since last clear, saturating at MAX_LEN.
REQ-017 SHALL shift data into history only on cycles with data_valid=1 and cfg_load=0; idle cycles change no state.
REQ-018 SHALL assert hit when data_valid=1, cfg_load=0, config legal, fill >= cfg_len-1, and the low cfg_len bits of {history, data} equal the low cfg_len bits of cfg_pattern.
REQ-019 SHALL, on hit with cfg_overlap=1, keep fill and history so a pattern suffix can begin the next match.
REQ-020 SHALL, on hit with cfg_overlap=0, reset fill to 0 so the next match uses only bits after the completing bit.
REQ-021 SHALL drive hit_q = hit of the previous cycle (latency 1).
REQ-022 SHALL increment hit_cnt by 1 per hit, saturating at 2^CNT_W-1 with no wrap.
REQ-023 SHALL give cnt_clr priority over a simultaneous increment (result 0).
REQ-024 SHALL, on cfg_load, latch config, clear fill and history, suppress hit that cycle, and discard any simultaneous data bit.
REQ-025 SHALL treat cfg_len=0 or cfg_len>MAX_LEN as illegal: hit never asserts; history still shifts.
REQ-026 SHALL, for cfg_len=1, assert hit on every valid bit equal to cfg_pattern[0] in both modes.

Reset
REQ-027 SHALL on rst_n=0 asynchronously clear history, fill, hit_q, hit_cnt to 0; cfg_pattern to 3'b101 zero-extended, cfg_len to 3, cfg_overlap to 1.
REQ-028 SHALL hold hit=0 while rst_n=0; reset mid-match discards all partial progress.

Configuration
REQ-029 SHALL use macro SEQDET_HITCNT_EN: defined -> hit counter and cnt_clr logic as REQ-022/023; undefined -> no counter register, hit_cnt tied 0, cnt_clr ignored.

Verification
REQ-030 SHALL cover: reset defaults, overlap=1, valid stream 1,0,1,0,1 -> hit on bits 3 and 5, hit_q one cycle later each, hit_cnt=2.
REQ-031 SHALL cover: cfg_load pattern 101 len 3 overlap=0, stream 1,0,1,0,1 -> hit on bit 3 only, hit_cnt=1.
REQ-032 SHALL cover: pattern 8'b11011011 len 8 overlap=1, stream with data_valid gaps between bits -> hit only on the eighth valid bit, none on idle cycles.
REQ-033 SHALL cover: rst_n pulsed low after bits 1,0 of 101 then bits 1 sent -> no hit until a full fresh 1,0,1.
REQ-034 SHALL cover: SEQDET_HITCNT_EN defined, CNT_W=2, five hits -> hit_cnt saturates at 3; cnt_clr with a hit same cycle -> hit_cnt=0.
REQ-035 SHALL cover: cfg_load with pat_len=0, then any stream -> hit stays 0; cfg_load concurrent with data_valid -> that bit ignored.

Source files
------------

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - serial pattern detector with runtime pattern/length/overlap config
// Optional hit counter: define SEQDET_HITCNT_EN to build hit_cnt/cnt_clr logic,
// otherwise hit_cnt is tied to zero and cnt_clr is ignored.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               data,
  input  logic               data_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               cnt_clr,
  output logic               hit,
  output logic               hit_q,
  output logic [CNT_W-1:0]   hit_cnt
);

  localparam logic [LEN_W-1:0]   MAX_LEN_V   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   RST_LEN     = LEN_W'(3);
  localparam logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(3'b101);

  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;

  // history[0] is the most recent accepted bit; fill counts accepted bits since last clear
  logic [MAX_LEN-2:0] history;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;
  logic               sample;
  logic               cfg_legal;
  logic               fill_ok;
  logic               match;

  assign window    = {history, data};
  assign sample    = data_valid & ~cfg_load;
  assign cfg_legal = (cfg_len != '0) && (cfg_len <= MAX_LEN_V);
  // fill >= cfg_len-1, evaluated one bit wider so cfg_len=0 cannot underflow
  assign fill_ok   = ((LEN_W+1)'(fill) + (LEN_W+1)'(1)) >= (LEN_W+1)'(cfg_len);

  // Select the low cfg_len bit positions that take part in the comparison
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(cfg_len));
    end
  end

  assign match = (((window ^ cfg_pattern) & len_mask) == '0);
  assign hit   = rst_n & sample & cfg_legal & fill_ok & match;

  // Config latch, history shift and fill tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_pattern <= RST_PATTERN;
      cfg_len     <= RST_LEN;
      cfg_overlap <= 1'b1;
      history     <= '0;
      fill        <= '0;
    end else if (cfg_load) begin
      cfg_pattern <= pattern;
      cfg_len     <= pat_len;
      cfg_overlap <= overlap;
      history     <= '0;
      fill        <= '0;
    end else if (data_valid) begin
      history <= window[MAX_LEN-2:0];
      if (hit && !cfg_overlap) begin
        fill <= '0;
      end else if (fill != MAX_LEN_V) begin
        fill <= fill + LEN_W'(1);
      end
    end
  end

  // Registered copy of the Mealy hit pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit;
    end
  end

`ifdef SEQDET_HITCNT_EN
  logic [CNT_W-1:0] cnt_r;

  // Saturating hit counter; clear wins over a same-cycle hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (cnt_clr) begin
      cnt_r <= '0;
    end else if (hit && (cnt_r != '1)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign hit_cnt = cnt_r;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign hit_cnt        = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - self-checking bench for seq_detector_param
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 5;
  localparam int CNT_W   = 2;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               data = 1'b0;
  logic               data_valid = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] pattern = '0;
  logic [LEN_W-1:0]   pat_len = '0;
  logic               overlap = 1'b0;
  logic               cnt_clr = 1'b0;
  logic               hit;
  logic               hit_q;
  logic [CNT_W-1:0]   hit_cnt;

  int checks = 0;
  int errors = 0;

  seq_detector_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid),
    .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
    .overlap(overlap), .cnt_clr(cnt_clr), .hit(hit), .hit_q(hit_q),
    .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: list of accepted bits since last clear, plus latched config
  bit       mq[$];
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl;
  int       m_cnt;

  typedef struct {
    bit       ld;
    bit [7:0] pat;
    bit [4:0] len;
    bit       ovl;
    bit       d;
    bit       v;
    bit       exp_hit;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_pat = 8'b101;
    m_len = 3;
    m_ovl = 1'b1;
    m_cnt = 0;
  endfunction

  // Newest bit is d (matches m_pat[0]); k bits back matches m_pat[k]
  function automatic bit model_hit(bit d, bit v, bit ld);
    if (!v || ld) return 1'b0;
    if (m_len == 0 || m_len > MAX_LEN) return 1'b0;
    if (mq.size() + 1 < m_len) return 1'b0;
    if (d != m_pat[0]) return 1'b0;
    for (int k = 1; k < m_len; k++) begin
      if (mq[mq.size() - k] != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int exp_cnt();
`ifdef SEQDET_HITCNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  function automatic void model_step(bit d, bit v, bit ld, bit clr, bit eh);
    if (ld) begin
      m_pat = pattern;
      m_len = int'(pat_len);
      m_ovl = overlap;
      mq.delete();
    end else if (v) begin
      mq.push_back(d);
      if (mq.size() > MAX_LEN - 1) void'(mq.pop_front());
      if (eh && !m_ovl) mq.delete();
    end
    if (clr) m_cnt = 0;
    else if (eh && m_cnt < CMAX) m_cnt++;
  endfunction

  // Entered at posedge+1; hit sampled at the falling edge, registered outputs after the next rise
  task automatic cycle(input bit d, input bit v, input bit ld, input bit clr, output logic got);
    bit eh;
    data = d; data_valid = v; cfg_load = ld; cnt_clr = clr;
    #4;
    eh  = model_hit(d, v, ld);
    got = hit;
    check("hit", {31'd0, hit}, {31'd0, eh});
    @(posedge clk); #1;
    model_step(d, v, ld, clr, eh);
    check("hit_q", {31'd0, hit_q}, {31'd0, eh});
    check("hit_cnt", {30'd0, hit_cnt}, exp_cnt());
  endtask

  task automatic do_reset();
    data = 1'b1; data_valid = 1'b1; cfg_load = 1'b0; cnt_clr = 1'b0;
    #2; rst_n = 1'b0; #1;
    check("hit_in_reset", {31'd0, hit}, 0);
    check("hit_q_reset", {31'd0, hit_q}, 0);
    check("hit_cnt_reset", {30'd0, hit_cnt}, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    data_valid = 1'b0;
  endtask

  function automatic void add(bit ld, bit [7:0] pat, bit [4:0] len, bit ovl, bit d, bit v, bit eh);
    vec_t t;
    t.ld = ld; t.pat = pat; t.len = len; t.ovl = ovl; t.d = d; t.v = v; t.exp_hit = eh;
    vecs.push_back(t);
  endfunction

  function automatic void add_bits(bit [15:0] bits, bit [15:0] exps, int n);
    for (int i = n - 1; i >= 0; i--) add(1'b0, 8'h00, 5'd0, 1'b0, bits[i], 1'b1, exps[i]);
  endfunction

  initial begin
    logic got;
    bit [7:0] p32;

    // Default config 101/3/overlap, then explicit non-overlap
    add_bits(16'b10101, 16'b00101, 5);
    add(1'b1, 8'b101, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    add_bits(16'b10101, 16'b00100, 5);
    // Eight-bit pattern with idle gaps, then an overlapping re-hit
    add(1'b1, 8'hDB, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    p32 = 8'hDB;
    for (int i = 7; i >= 0; i--) begin
      add(1'b0, 8'h00, 5'd0, 1'b0, p32[i], 1'b1, (i == 0));
      add(1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    add_bits(16'b011, 16'b001, 3);
    // Single-bit patterns in both modes
    add(1'b1, 8'h00, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    add_bits(16'b0100, 16'b1011, 4);
    add(1'b1, 8'h01, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    add_bits(16'b110, 16'b110, 3);
    // Illegal lengths never hit
    add(1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    add_bits(16'b0000, 16'b0000, 4);
    add(1'b1, 8'hFF, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    add_bits(16'h1FF, 16'h000, 9);
    // Bit presented with cfg_load is discarded
    add(1'b1, 8'b101, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    add_bits(16'b0101, 16'b0001, 4);

    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].ld) begin
        pattern = vecs[i].pat; pat_len = vecs[i].len; overlap = vecs[i].ovl;
      end
      cycle(vecs[i].d, vecs[i].v, vecs[i].ld, 1'b0, got);
      check($sformatf("vec%0d_hit", i), {31'd0, got}, {31'd0, vecs[i].exp_hit});
    end

    // Reset mid-match discards partial 1,0
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, got);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, got);
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, got);
    check("after_reset_first1", {31'd0, got}, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, got);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, got);
    check("fresh_101", {31'd0, got}, 1);

    // Counter saturation with five hits, then clear against a simultaneous hit
    do_reset();
    for (int i = 0; i < 11; i++) cycle(~i[0], 1'b1, 1'b0, 1'b0, got);
`ifdef SEQDET_HITCNT_EN
    check("cnt_saturated", {30'd0, hit_cnt}, 3);
`else
    check("cnt_tied_zero", {30'd0, hit_cnt}, 0);
`endif
    cycle(1'b0, 1'b1, 1'b0, 1'b0, got);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, got);
    check("clr_with_hit", {31'd0, got}, 1);
    check("cnt_after_clr", {30'd0, hit_cnt}, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit ld, v, d, clr;
      ld  = ($urandom_range(0, 49) == 0);
      v   = ($urandom_range(0, 9) < 7);
      d   = $urandom_range(0, 1);
      clr = ($urandom_range(0, 39) == 0);
      if (ld) begin
        pattern = 8'($urandom);
        pat_len = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(1, 4)) : 5'($urandom_range(0, 10));
        overlap = $urandom_range(0, 1);
      end
      if (i == 1500) do_reset();
      cycle(d, v, ld, clr, got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
